wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface.
- Consumes the registered `mem_wb_bus_t` and builds the final write-back value: ALU result, formatted load data, or PC+4.
- Commits that value into the 32x32 integer register file and serves the two combinational read ports used by decode.
- Keeps a 64-bit retired-instruction counter and drives the WB-stage forwarding tap for the hazard unit.

Parameters:
- XLEN, 32, data width of registers and bus fields.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 64, width of the retire counter.

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESET  input  1  reset, synchronous, active-high.
- stall_en  input  1  pipeline stall; WB contents are held upstream.
- mem_wb_bus_in  input  mem_wb_bus_t  MEM/WB register output.
- rs1_addr  input  5  decode read address A.
- rs2_addr  input  5  decode read address B.
- rs1_data  output  XLEN  read data A, combinational.
- rs2_data  output  XLEN  read data B, combinational.
- wb_fwd_we  output  1  WB write is pending this cycle.
- wb_fwd_rd  output  5  WB destination register.
- wb_fwd_data  output  XLEN  WB write value.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- Reset: on a rising edge with ARESET=1, x1..x31 clear to 0 and retired clears to 0. Reset wins over a simultaneous write.
  - Combinational outputs follow their inputs during reset.
  - Forwarding outputs derive from the bus, which upstream clears to '0 on reset; wb_fwd_we is therefore 0 after reset.
- Write-back select on wb_sel:
  - 0: alu_result.
  - 1: formatted load data.
  - 2: pc_plus4.
  - 3: reserved; drives 0.
- Load formatting (combinational) uses funct3 and addr_lo:
  - LB (0): mem_rdata byte at addr_lo, sign-extended.
  - LH (1): halfword at addr_lo[1], sign-extended.
  - LW (2): full word.
  - LBU (4): byte, zero-extended.
  - LHU (5): halfword, zero-extended.
  - Any other funct3: full word.
  - Misaligned LH/LW are not checked here; LH uses addr_lo[1] only.
- Write enable: we = valid & rd_we & (rd_addr != 0).
  - The register array is written at the clock edge when we=1.
  - Writes to x0 are discarded; x0 always reads 0.
- Stall:
  - The write still occurs under stall. It is idempotent because the bus is held.
  - retired increments only when valid & !stall_en, so a held instruction counts exactly once.
  - Instructions without rd_we, such as stores and branches, also count when valid.
- Read ports (combinational):
  - Address 0 returns 0.
  - Write-through bypass: if we=1 and rd_addr == rsX_addr, return the current write-back value. Otherwise return the array entry.
  - Both ports may bypass in the same cycle.
- Forwarding tap: wb_fwd_we = we, wb_fwd_rd = rd_addr, wb_fwd_data = write-back value.
- Retire counter wraps from 2^64-1 to 0 silently.
- Latency:
  - A write is visible in the array on the next cycle.
  - Through the bypass it is visible in the same cycle.

Decomposition:
- Shared package `rv32i_pkg` holds:
  - The `mem_wb_bus_t` fields: valid, rd_we, rd_addr[4:0], wb_sel[1:0], funct3[2:0], addr_lo[1:0], alu_result, mem_rdata, pc_plus4.
  - A `wb_sel_e` enum with values WB_ALU, WB_MEM, WB_PC4.
  - funct3 load constants.
- One sub-module: `load_formatter`, purely combinational. Inputs: funct3, addr_lo, mem_rdata. Output: formatted data.

Test Plan:
- Reset and x0:
  - Stimulus: pulse ARESET, then attempt a write of 0xDEADBEEF to x0.
  - Required: every register reads 0, retired=0, and x0 still reads 0 after the write.
- Bypass:
  - Stimulus: write x5=0x12345678 via WB_ALU with rs1_addr=rs2_addr=5 in the same cycle.
  - Required: both read ports return 0x12345678 in that cycle, and the array holds the value the next cycle.
- Load formatting:
  - Stimulus: mem_rdata=0x80F17F01 with each funct3/addr_lo combination. Expected results:
    - LB, addr_lo=3: 0xFFFFFF80.
    - LBU, addr_lo=1: 0x0000007F.
    - LH, addr_lo=2: 0xFFFF80F1.
    - LHU, addr_lo=0: 0x00007F01.
    - LW: 0x80F17F01.
- Stall:
  - Stimulus: hold a valid instruction for 3 cycles with stall_en=1, then 1 cycle with stall_en=0.
  - Required: retired increases by exactly 1, and the register holds the written value.
- Reset vs write collision:
  - Stimulus: assert ARESET in the same cycle as a write of x7=0xAAAA5555.
  - Required: x7 reads 0 afterwards.
- JAL link:
  - Stimulus: wb_sel=WB_PC4, pc_plus4=0x00000104, rd=1.
  - Required: x1 = 0x00000104, and the forwarding tap shows we=1, rd=1, data=0x104 during the cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: the MEM/WB bus layout, write-back source
// selector encodings and the load funct3 codes used by the write-back stage.
package rv32i_pkg;

   localparam int RV_XLEN  = 32;
   localparam int RV_NREGS = 32;
   localparam int RV_CNT_W = 64;

   // Write-back source selector; encoding 3 is reserved and produces zero
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Registered MEM/WB pipeline bus
   typedef struct packed {
      logic                valid;
      logic                rd_we;
      logic [4:0]          rd_addr;
      logic [1:0]          wb_sel;
      logic [2:0]          funct3;
      logic [1:0]          addr_lo;
      logic [RV_XLEN-1:0]  alu_result;
      logic [RV_XLEN-1:0]  mem_rdata;
      logic [RV_XLEN-1:0]  pc_plus4;
   } mem_wb_bus_t;

endpackage

// File: rtl/load_formatter.sv
// Shapes raw memory read data into the architectural load result: picks
// the addressed byte or halfword and sign- or zero-extends it.
module load_formatter
   import rv32i_pkg::*;
(
   input  logic [2:0]         i_funct3,
   input  logic [1:0]         i_addrLo,
   input  logic [RV_XLEN-1:0] i_memRdata,
   output logic [RV_XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and halfword; halfwords only look at addr bit 1
   always_comb begin
      w_byte = 8'd0;
      w_half = 16'd0;
      case (i_addrLo)
         2'd0:    w_byte = i_memRdata[7:0];
         2'd1:    w_byte = i_memRdata[15:8];
         2'd2:    w_byte = i_memRdata[23:16];
         default: w_byte = i_memRdata[31:24];
      endcase
      w_half = i_addrLo[1] ? i_memRdata[31:16] : i_memRdata[15:0];
   end

   // Extend according to the load type; unknown codes pass the full word
   always_comb begin
      o_data = i_memRdata;
      case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LW:   o_data = i_memRdata;
         F3_LBU:  o_data = {24'd0, w_byte};
         F3_LHU:  o_data = {16'd0, w_half};
         default: o_data = i_memRdata;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: builds the write-back value,
// commits it, serves two bypassed read ports, counts retired instructions
// and exposes the WB forwarding tap to the hazard unit.
module wb_regfile
   import rv32i_pkg::*;
#(
   parameter int XLEN  = RV_XLEN,
   parameter int NREGS = RV_NREGS,
   parameter int CNT_W = RV_CNT_W
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              stall_en,
   input  mem_wb_bus_t       mem_wb_bus_in,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   output logic              wb_fwd_we,
   output logic [4:0]        wb_fwd_rd,
   output logic [XLEN-1:0]   wb_fwd_data,
   output logic [CNT_W-1:0]  retired
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [CNT_W-1:0] r_retired;
   logic [XLEN-1:0]  w_loadData;
   logic [XLEN-1:0]  w_wbData;
   logic             w_we;

   load_formatter u_loadFormatter (
      .i_funct3   (mem_wb_bus_in.funct3),
      .i_addrLo   (mem_wb_bus_in.addr_lo),
      .i_memRdata (mem_wb_bus_in.mem_rdata),
      .o_data     (w_loadData)
   );

   // Writes to x0 are dropped here so x0 never leaves zero
   assign w_we = mem_wb_bus_in.valid & mem_wb_bus_in.rd_we
               & (mem_wb_bus_in.rd_addr != 5'd0);

   // Choose the write-back source; the reserved encoding yields zero
   always_comb begin
      w_wbData = '0;
      case (mem_wb_bus_in.wb_sel)
         WB_ALU:  w_wbData = mem_wb_bus_in.alu_result;
         WB_MEM:  w_wbData = w_loadData;
         WB_PC4:  w_wbData = mem_wb_bus_in.pc_plus4;
         default: w_wbData = '0;
      endcase
   end

   // Register array commit; reset clears everything and beats a same-cycle write
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_we) begin
         r_regs[mem_wb_bus_in.rd_addr] <= w_wbData;
      end
   end

   // Retire counter; a stalled instruction is held upstream and counted once it moves on
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_retired <= '0;
      end else if (mem_wb_bus_in.valid && !stall_en) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Read ports: x0 is zero, a pending write to the same register bypasses the array
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != 5'd0) begin
         if (w_we && (mem_wb_bus_in.rd_addr == rs1_addr)) begin
            rs1_data = w_wbData;
         end else begin
            rs1_data = r_regs[rs1_addr];
         end
      end
      if (rs2_addr != 5'd0) begin
         if (w_we && (mem_wb_bus_in.rd_addr == rs2_addr)) begin
            rs2_data = w_wbData;
         end else begin
            rs2_data = r_regs[rs2_addr];
         end
      end
   end

   // Forwarding tap mirrors the write about to be committed
   always_comb begin
      wb_fwd_we   = w_we;
      wb_fwd_rd   = mem_wb_bus_in.rd_addr;
      wb_fwd_data = w_wbData;
   end

   assign retired = r_retired;

endmodule
